// File: rtl/ag32gbd_frame_scanner.sv
`timescale 1ns/1ps
// ag32gbd_frame_scanner
// Walks the single-pixel sampler across one camera frame in raster order
// (X fastest). It packs four 2-bit samples per byte and writes each byte to
// the frame buffer.
//
// Frame-buffer handshake: FbWriteEn is the valid. While it is high,
// FbWriteAddr and FbWriteData stay frozen. A byte is transferred on every
// clock edge where FbWriteEn && FbWriteReady. FbWriteEn drops on the cycle
// after that transfer. No timeout applies to a stalled write.
//
// FrameStart goes through one input register before its edge detector. As a
// result, SampleStart rises on the second clock edge after FrameStart goes
// high.
module ag32gbd_frame_scanner #(
    parameter int FRAME_W    = 128,
    parameter int FRAME_H    = 112,
    parameter int START_HOLD = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic        sys_clock,
    input  logic        sys_reset,
    input  logic        FrameStart,
    input  logic        FrameAbort,
    output logic        SampleStart,
    output logic [6:0]  PixelX,
    output logic [6:0]  PixelY,
    input  logic        SampleDone,
    input  logic [1:0]  SampledValue,
    output logic        FbWriteEn,
    output logic [11:0] FbWriteAddr,
    output logic [7:0]  FbWriteData,
    input  logic        FbWriteReady,
    output logic        FrameBusy,
    output logic        FrameDone,
    output logic        SampleTimeout,
    output logic [6:0]  fsm_state
);

    typedef enum logic [6:0] {
        IDLE   = 7'b0000001,
        START  = 7'b0000010,
        WAIT   = 7'b0000100,
        SETTLE = 7'b0001000,
        WRITE  = 7'b0010000,
        NEXT   = 7'b0100000,
        DONE   = 7'b1000000
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [6:0]  X_LAST         = 7'(FRAME_W - 1);
    localparam logic [6:0]  Y_LAST         = 7'(FRAME_H - 1);
    localparam logic [11:0] BYTES_PER_LINE = 12'(FRAME_W / 4);

    state_t           state;
    state_t           state_n;
    logic             fs_q;
    logic             fs_prev;
    logic             done_prev;
    logic             fs_edge;
    logic             done_edge;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       pack;
    logic             start_frame;
    logic             take_sample;
    logic             take_timeout;
    logic [11:0]      y_ext;
    logic [11:0]      x_byte;

    assign fs_edge   = fs_q & ~fs_prev;
    assign done_edge = SampleDone & ~done_prev;

    // Input registers used for FrameStart and SampleDone edge detection.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            fs_q      <= 1'b0;
            fs_prev   <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            fs_q      <= FrameStart;
            fs_prev   <= fs_q;
            done_prev <= SampleDone;
        end
    end

    // State register.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and datapath strobes. An abort overrides everything.
    always_comb begin
        state_n      = state;
        start_frame  = 1'b0;
        take_sample  = 1'b0;
        take_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (fs_edge) begin
                    start_frame = 1'b1;
                    state_n     = START;
                end
            end
            START: begin
                // cnt starts at 0 on the first START cycle.
                // It doubles as the hold counter.
                if (cnt == HOLD_LAST) state_n = WAIT;
            end
            WAIT: begin
                // An edge in the expiry cycle wins over the timeout.
                if (done_edge) begin
                    take_sample = 1'b1;
                    state_n     = SETTLE;
                end else if (cnt == TMO_LAST) begin
                    take_timeout = 1'b1;
                    state_n      = SETTLE;
                end
            end
            SETTLE: begin
                // Wait out the stretched done pulse before the next start.
                if (!SampleDone) state_n = (PixelX[1:0] == 2'd3) ? WRITE : NEXT;
            end
            WRITE: begin
                if (FbWriteReady) state_n = NEXT;
            end
            NEXT: begin
                state_n = (PixelX == X_LAST && PixelY == Y_LAST) ? DONE : START;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (FrameAbort) begin
            state_n      = IDLE;
            start_frame  = 1'b0;
            take_sample  = 1'b0;
            take_timeout = 1'b0;
        end
    end

    // Pixel coordinates, timeout/hold counter, pack register and sticky timeout flag.
    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            PixelX        <= '0;
            PixelY        <= '0;
            cnt           <= '0;
            pack          <= '0;
            SampleTimeout <= 1'b0;
        end else if (FrameAbort) begin
            pack <= '0;
        end else if (start_frame) begin
            PixelX        <= '0;
            PixelY        <= '0;
            cnt           <= '0;
            pack          <= '0;
            SampleTimeout <= 1'b0;
        end else begin
            if (state == START || state == WAIT) cnt <= cnt + 1'b1;
            if (take_sample) pack <= {pack[5:0], SampledValue};
            if (take_timeout) begin
                pack          <= {pack[5:0], 2'b00};
                SampleTimeout <= 1'b1;
            end
            if (state == NEXT) begin
                cnt <= '0;
                if (PixelX == X_LAST) begin
                    PixelX <= '0;
                    if (PixelY != Y_LAST) PixelY <= PixelY + 1'b1;
                end else begin
                    PixelX <= PixelX + 1'b1;
                end
            end
        end
    end

    assign y_ext       = {5'd0, PixelY};
    assign x_byte      = {7'd0, PixelX[6:2]};
    assign FbWriteAddr = y_ext * BYTES_PER_LINE + x_byte;
    assign FbWriteData = pack;
    assign SampleStart = (state == START);
    assign FbWriteEn   = (state == WRITE);
    assign FrameDone   = (state == DONE);
    assign FrameBusy   = (state != IDLE) && (state != DONE);
    assign fsm_state   = state;

endmodule
